mem_port_arbiter: RTL

- Shares one single-port, asynchronously read word memory between two requesters: the instruction-fetch port (IF) and the data-access port (D).
- Sits between the core's fetch/LSU logic and the memory array, in the multicycle/unified-memory configuration.
- Grants one request at a time, latches its command, and models a configurable access latency with a down-counter.
- Returns the read data through a one-cycle valid pulse.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/rr_grant2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } arb_state_e;

  // Which requester owns the in-flight access.
  typedef enum logic {
    OwnIf = 1'b0,
    OwnD  = 1'b1
  } owner_e;

  // Latency down-counter width; covers MEM_LATENCY up to 15.
  localparam int unsigned CntW = 4;

endpackage

// File: rtl/rr_grant2.sv
// Combinational 2-way round-robin grant: bit 0 = IF, bit 1 = D.
module rr_grant2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_grant,
  output logic [1:0] gnt
);

  // On a tie, favour whichever port was not granted last.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == OwnD) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an asynchronously read single-port memory between the
// instruction-fetch and data ports, with a fixed per-access latency.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CntW-1:0] CntInit = CntW'(MEM_LATENCY - 1);

  arb_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]        gnt;
  logic              accept;

  rr_grant2 u_rr_grant2 (
    .req        ({d_req, if_req}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign accept = (state_q == StIdle) && (gnt != 2'b00);

  // Next-state: grant/latch in idle, count down the access, then respond.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d      = gnt[1] ? OwnD : OwnIf;
          last_grant_d = gnt[1] ? OwnD : OwnIf;
          addr_d       = gnt[1] ? d_addr : if_addr;
          we_d         = gnt[1] & d_we;
          wdata_d      = gnt[1] ? d_wdata : '0;
          cnt_d        = CntInit;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Final access cycle: the array write happens now, or read data is sampled.
          if (we_q) begin
            d_rdata_d = '0;
          end else if (owner_q == OwnD) begin
            d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; an aborted access simply vanishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      owner_q      <= OwnIf;
      last_grant_q <= OwnD;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Outputs decoded from registers; forced to their reset values while reset is high.
  always_comb begin
    if_ready  = !reset && (state_q == StIdle) && gnt[0];
    d_ready   = !reset && (state_q == StIdle) && gnt[1];
    if_valid  = !reset && (state_q == StResp) && (owner_q == OwnIf);
    d_valid   = !reset && (state_q == StResp) && (owner_q == OwnD);
    mem_en    = !reset && (state_q == StAccess);
    mem_we    = mem_en && (cnt_q == '0) && we_q;
    busy      = !reset && (state_q != StIdle);
    mem_addr  = reset ? '0 : addr_q;
    mem_wdata = reset ? '0 : wdata_q;
    if_rdata  = reset ? '0 : if_rdata_q;
    d_rdata   = reset ? '0 : d_rdata_q;
  end

endmodule
